// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with per-row debounce.
// Emits a single-cycle one-hot pulse, binary index and valid strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] onehot,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DEB_ONE    = DW'(1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_RELEASE
  } state_t;

  logic [3:0]    col_meta_q, col_sync_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] deb_q, deb_d;
  state_t        state_q, state_d;
  logic [15:0]   onehot_q, onehot_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic          sample;
  logic          hit;
  logic [1:0]    hit_col;
  logic [DW-1:0] deb_inc;
  logic          emit;
  logic [3:0]    emit_idx;

  // Columns are asynchronous to clk; two flops before anything looks at them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  // Exactly one low column is a hit; anything else (idle, ghosting, multi-key) is ignored.
  always_comb begin
    hit     = 1'b1;
    hit_col = 2'd0;
    case (col_sync_q)
      4'b1110: hit_col = 2'd0;
      4'b1101: hit_col = 2'd1;
      4'b1011: hit_col = 2'd2;
      4'b0111: hit_col = 2'd3;
      default: hit     = 1'b0;
    endcase
  end

  assign sample  = (slot_q == SLOT_LAST);
  assign slot_d  = sample ? '0 : slot_q + SW'(1);
  assign deb_inc = deb_q + DEB_ONE;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    deb_d    = deb_q;
    emit     = 1'b0;
    emit_idx = 4'h0;

    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (hit) begin
            col_d = hit_col;
            if (DEB_TARGET == DEB_ONE) begin
              emit     = 1'b1;
              emit_idx = {row_q, hit_col};
              deb_d    = '0;
              state_d  = ST_RELEASE;
            end else begin
              deb_d   = DEB_ONE;
              state_d = ST_DEBOUNCE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (hit && (hit_col == col_q)) begin
            if (deb_inc == DEB_TARGET) begin
              emit     = 1'b1;
              emit_idx = {row_q, col_q};
              deb_d    = '0;
              state_d  = ST_RELEASE;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = ST_SCAN;
          end
        end

        ST_RELEASE: begin
          // Only the latched column matters; other keys in the held row are ignored.
          if (col_sync_q[col_q]) begin
            if (deb_inc == DEB_TARGET) begin
              deb_d   = '0;
              row_d   = 2'd0;
              state_d = ST_SCAN;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d = '0;
          end
        end

        default: begin
          deb_d   = '0;
          row_d   = 2'd0;
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  always_comb begin
    onehot_d = 16'h0000;
    valid_d  = 1'b0;
    code_d   = code_q;
    if (emit) begin
      onehot_d = 16'h0001 << emit_idx;
      valid_d  = 1'b1;
      code_d   = emit_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q   <= '0;
      row_q    <= 2'd0;
      col_q    <= 2'd0;
      deb_q    <= '0;
      state_q  <= ST_SCAN;
      onehot_q <= 16'h0000;
      code_q   <= 4'h0;
      valid_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      row_q    <= row_d;
      col_q    <= col_d;
      deb_q    <= deb_d;
      state_q  <= state_d;
      onehot_q <= onehot_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
    end
  end

  assign row_out   = ~(4'b0001 << row_q);
  assign onehot    = onehot_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a 4x4 keypad model driven by
// directed press/release vectors plus hand-timed bounce and mid-debounce reset sequences.
module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;
   localparam int NVEC         = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [15:0] onehot;
   logic [3:0]  key_code;
   logic        key_valid;

   logic [15:0] pressed = 16'h0000;

   int          total = 0;
   int          bad = 0;
   int          pulse_cnt = 0;
   logic [15:0] last_onehot = 16'h0000;
   logic        prev_valid = 1'b0;

   typedef struct {
      logic [15:0] keys;
      int          hold;
      int          exp_pulses;
      logic [15:0] exp_onehot;
      logic [3:0]  exp_code;
      bit          chk_row;
      logic [3:0]  exp_row;
   } vec_t;

   vec_t vecs [NVEC];

   keypad_scanner #(
      .SCAN_DIV    (SCAN_DIV),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .col_in   (col_in),
      .row_out  (row_out),
      .onehot   (onehot),
      .key_code (key_code),
      .key_valid(key_valid)
   );

   // free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // keypad model: a pressed key shorts its row to its column, so a column
   // reads low whenever a pressed key sits in the row being driven low
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row_out[r] && pressed[r*4+c])
               col_in[c] = 1'b0;
   end

   // compare one observed value against its expected value and log any miss
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // hold a key mask on the keypad for a number of clock cycles
   task automatic applyStimulus(input logic [15:0] keys, input int cycles);
      pressed = keys;
      repeat (cycles) @(negedge clk);
   endtask

   // wait (bounded) for row_out to step from one row pattern to another
   task automatic waitRowEdge(input logic [3:0] from_row, input logic [3:0] to_row, output bit found);
      logic [3:0] prev;
      prev  = row_out;
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (prev == from_row && row_out == to_row) begin
            found = 1'b1;
            break;
         end
         prev = row_out;
      end
   endtask

   // pulse monitor: counts strobes, remembers the last code, and checks that
   // pulses are single-cycle and that onehot is quiet between them
   always @(negedge clk) begin
      if (key_valid) begin
         pulse_cnt++;
         last_onehot = onehot;
         checkOutput("no_back_to_back", 32'(prev_valid), 32'd0);
      end else begin
         checkOutput("idle_onehot_zero", 32'(onehot), 32'd0);
      end
      prev_valid = key_valid;
   end

   // global watchdog so the bench always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // main stimulus sequence
   initial begin
      logic [3:0] exp_rows [5];
      bit         found;
      int         n;

      exp_rows[0] = 4'b1110;
      exp_rows[1] = 4'b1101;
      exp_rows[2] = 4'b1011;
      exp_rows[3] = 4'b0111;
      exp_rows[4] = 4'b1110;

      vecs[0] = '{16'h0040, 200, 1, 16'h0040, 4'd6,  1'b1, 4'b1101};
      vecs[1] = '{16'h0300, 100, 0, 16'h0000, 4'd6,  1'b0, 4'b0000};
      vecs[2] = '{16'h0100, 100, 1, 16'h0100, 4'd8,  1'b1, 4'b1011};
      vecs[3] = '{16'h0000, 40,  0, 16'h0000, 4'd8,  1'b0, 4'b0000};
      vecs[4] = '{16'h8000, 100, 1, 16'h8000, 4'd15, 1'b1, 4'b0111};
      vecs[5] = '{16'h8002, 100, 0, 16'h0000, 4'd15, 1'b1, 4'b0111};
      vecs[6] = '{16'h0002, 100, 1, 16'h0002, 4'd1,  1'b1, 4'b1110};
      vecs[7] = '{16'h0000, 40,  0, 16'h0000, 4'd1,  1'b0, 4'b0000};
      vecs[8] = '{16'h0800, 100, 1, 16'h0800, 4'd11, 1'b1, 4'b1011};
      vecs[9] = '{16'h0000, 40,  0, 16'h0000, 4'd11, 1'b0, 4'b0000};

      rst_n   = 1'b0;
      pressed = 16'h0000;
      repeat (2) @(negedge clk);
      checkOutput("rst_row_out",   32'(row_out),   32'h0000000E);
      checkOutput("rst_onehot",    32'(onehot),    32'd0);
      checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
      checkOutput("rst_key_code",  32'(key_code),  32'd0);

      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         repeat ((k == 0) ? 2 : 4) @(negedge clk);
         checkOutput($sformatf("idle_scan_row%0d", k), 32'(row_out), 32'(exp_rows[k]));
      end

      // bouncy r0c0: two good samples, then an open sample, then stable
      waitRowEdge(4'b0111, 4'b1110, found);
      checkOutput("bounce_align", 32'(found), 32'd1);
      pulse_cnt = 0;
      applyStimulus(16'h0001, 8);
      applyStimulus(16'h0000, 4);
      checkOutput("bounce_no_pulse", 32'(pulse_cnt), 32'd0);
      checkOutput("bounce_row_advanced", 32'(row_out), 32'b1101);
      applyStimulus(16'h0001, 100);
      checkOutput("bounce_pulses", 32'(pulse_cnt), 32'd1);
      checkOutput("bounce_onehot", 32'(last_onehot), 32'h0001);
      checkOutput("bounce_code", 32'(key_code), 32'd0);
      applyStimulus(16'h0000, 40);

      for (int i = 0; i < NVEC; i++) begin
         pulse_cnt = 0;
         applyStimulus(vecs[i].keys, vecs[i].hold);
         checkOutput($sformatf("v%0d_pulses", i), 32'(pulse_cnt), 32'(vecs[i].exp_pulses));
         if (vecs[i].exp_pulses > 0)
            checkOutput($sformatf("v%0d_onehot", i), 32'(last_onehot), 32'(vecs[i].exp_onehot));
         checkOutput($sformatf("v%0d_code", i), 32'(key_code), 32'(vecs[i].exp_code));
         if (vecs[i].chk_row)
            checkOutput($sformatf("v%0d_row", i), 32'(row_out), 32'(vecs[i].exp_row));

         // release of r1c2: row must hold until three high samples, then jump to row 0
         if (i == 0) begin
            pressed = 16'h0000;
            n = 0;
            for (int w = 1; w <= 60; w++) begin
               @(negedge clk);
               if (row_out != 4'b1101) begin
                  n = w;
                  break;
               end
            end
            checkOutput("release_row", 32'(row_out), 32'b1110);
            checkOutput("release_delay_in_range", 32'(n >= 11 && n <= 14), 32'd1);
            applyStimulus(16'h0000, 20);
         end
      end

      // r1c0 with reset asserted after two good samples
      waitRowEdge(4'b1110, 4'b1101, found);
      checkOutput("midrst_align", 32'(found), 32'd1);
      pulse_cnt = 0;
      applyStimulus(16'h0010, 9);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_row_out",   32'(row_out),   32'h0000000E);
      checkOutput("midrst_onehot",    32'(onehot),    32'd0);
      checkOutput("midrst_key_valid", 32'(key_valid), 32'd0);
      checkOutput("midrst_key_code",  32'(key_code),  32'd0);
      repeat (3) @(negedge clk);
      checkOutput("midrst_no_pulse", 32'(pulse_cnt), 32'd0);
      rst_n = 1'b1;
      applyStimulus(16'h0010, 100);
      checkOutput("midrst_pulses", 32'(pulse_cnt), 32'd1);
      checkOutput("midrst_onehot_after", 32'(last_onehot), 32'h0010);
      checkOutput("midrst_code_after", 32'(key_code), 32'd4);
      applyStimulus(16'h0000, 40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad and debounces it.
- Emits one single-cycle 16-bit one-hot code per debounced key press, plus a binary index and a valid strobe.
- Sits between the keypad pins and the password/display one-hot-to-binary encoder.
- Produces the 16-bit one-hot word that the encoder consumes; the encoder ignores an all-zero word.

Parameters:
- SCAN_DIV, 50000: clk cycles per row slot. Columns are sampled once, in the last cycle of each slot. Must be >= 2.
- DEBOUNCE_CNT, 10: consecutive matching samples required to accept a press, and the same number to accept a release. Must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- col_in  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk.
- row_out  out  4  keypad row drive, active-low; exactly one bit is low at all times.
- onehot  out  16  one-cycle pulse; bit (row*4+col) is set on an accepted press; 16'h0000 otherwise.
- key_code  out  4  row*4+col of the last accepted key; held until the next accepted press.
- key_valid  out  1  one-cycle strobe, coincident with onehot.

Behaviour:
- Reset (async assert, sync release) values: row_out=4'b1110, onehot=16'h0000, key_code=4'h0, key_valid=0, state=SCAN, row index=0, slot counter=0, debounce counter=0, synchroniser flops=4'hF.
- col_in passes through a 2-flop synchroniser. Every "sample" in this spec means the synchronised value taken in the last cycle of a slot (slot counter == SCAN_DIV-1).
- A sample is a "single hit" at column c when exactly one bit of the synchronised col_in is 0, at bit c.
- Zero or more than one low bit counts as "no key"; ghosting and multi-key presses are never reported.
- The slot counter runs 0..SCAN_DIV-1 and wraps in every state.
- State SCAN:
  - On each sample with no hit: the row index advances (3 wraps to 0) and row_out updates on the next cycle.
  - On a single hit: latch row/col, set the debounce counter to 1, go to DEBOUNCE. The row is held.
- State DEBOUNCE (row held):
  - Sample is a single hit at the latched col: the counter increments.
  - When the counter reaches DEBOUNCE_CNT: in the cycle after that sample, onehot = 1<<(row*4+col), key_valid=1 and key_code is updated, for exactly one cycle. Then go to RELEASE with the counter cleared.
  - Any other sample: go to SCAN, clear the counter, advance to the next row.
  - With DEBOUNCE_CNT=1 the pulse follows the first hit directly.
- State RELEASE (row held):
  - Sample with latched column bit = 1: the counter increments.
  - Sample with latched column bit = 0: the counter clears.
  - When the counter reaches DEBOUNCE_CNT: go to SCAN at row index 0.
  - A held key never repeats. Keys pressed in other rows while a key is held are ignored.
- Keys are accepted at most once per slot sample, so onehot is never asserted on two consecutive cycles.
- Latency from a clean press in the currently driven row: 2 sync cycles + (DEBOUNCE_CNT-1) full slots + the remainder of the current slot + 1 output cycle.
- Reset mid-operation: all outputs return to reset values immediately. A pending debounce is discarded and no pulse is emitted for it.
- Key index mapping: row r (row_out bit r low) and column c (col_in bit c low) give index r*4+c. Examples: r0c0→0x0001, r1c2→0x0040, r3c3→0x8000.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, keypad model connects row r to col c while pressed):
- Reset: rst_n low → row_out=4'b1110, onehot=0, key_valid=0, key_code=0. After release, row_out cycles 1110→1101→1011→0111→1110, one step every 4 clk.
- Clean press r1c2 held 200 cycles → exactly one key_valid pulse with onehot=16'h0040 and key_code=6. row_out stays 4'b1101 until the key is released plus 3 high samples, then returns to 4'b1110.
- Bouncy press r0c0: 2 good samples, 1 open, then stable → no pulse after the first attempt. A single onehot=16'h0001 pulse is emitted after 3 consecutive good samples.
- Two keys pressed in the same row (r2c0 and r2c1) → no pulse. Releasing r2c1 alone → onehot=16'h0100, key_code=8.
- Hold r3c3, then press r0c1 while r3c3 is held → only 16'h8000 is reported. After r3c3 is released, the still-held r0c1 gives 16'h0002.
- Press r1c0 and assert rst_n after 2 good samples → outputs reset immediately and no pulse is emitted. After release with the key still held, a fresh full debounce yields onehot=16'h0010.
